// File: rtl/gcbp_pkg.sv
// gcbp_pkg: shared types and default geometry for the gray-code bit-plane scheduler
package gcbp_pkg;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACTIVE, S_TAIL} state_t;

    localparam int DEF_LINES    = 480;
    localparam int DEF_SUB_H    = 64;
    localparam int DEF_NUM_VERT = 4;
    localparam int DEF_EDGE     = 46;
    localparam int DEF_GAP      = 44;

    // first line of sub-image row k
    function automatic int win_start(input int k, input int edge_l = DEF_EDGE,
                                     input int sub_h = DEF_SUB_H, input int gap = DEF_GAP);
        return edge_l + k * (sub_h + gap);
    endfunction

endpackage

// File: rtl/gcbp_frame_slot_rotator.sv
// gcbp_frame_slot_rotator: next/curr/prev frame slot pointers, rotated once per completed frame
module gcbp_frame_slot_rotator (
    input  logic       i_clk,
    input  logic       i_resetn,
    input  logic       i_rotate,
    output logic [1:0] o_next,
    output logic [1:0] o_curr,
    output logic [1:0] o_prev
);

    // the finished "next" frame becomes current; the oldest slot is reused for writing
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            o_next <= 2'd0;
            o_curr <= 2'd1;
            o_prev <= 2'd2;
        end else if (i_rotate) begin
            o_prev <= o_curr;
            o_curr <= o_next;
            o_next <= o_prev;
        end
    end

    // the three pointers must always be a permutation of {0,1,2}
    always_ff @(posedge i_clk) begin
        if (i_resetn)
            assert (o_next != o_curr && o_curr != o_prev && o_next != o_prev &&
                    o_next != 2'd3 && o_curr != 2'd3 && o_prev != 2'd3);
    end

endmodule

// File: rtl/gcbp_subimage_scheduler.sv
// gcbp_subimage_scheduler: tracks sub-image row/line of incoming video and generates BRAM write addresses
module gcbp_subimage_scheduler
    import gcbp_pkg::*;
#(
    parameter int P_NUM_VERT  = DEF_NUM_VERT,
    parameter int P_SUB_H     = DEF_SUB_H,
    parameter int P_LINES     = DEF_LINES,
    parameter int P_EDGE      = DEF_EDGE,
    parameter int P_GAP       = DEF_GAP,
    parameter int P_LINE_BITS = 10,
    parameter int P_ADDR_BITS = 9
) (
    input  logic                                               i_clk,
    input  logic                                               i_resetn,
    input  logic                                               i_enable,
    input  logic                                               i_new_frame,
    input  logic                                               i_new_line,
    input  logic [P_LINE_BITS-1:0]                             i_line_cnt,
    output logic                                               o_line_valid,
    output logic [(P_NUM_VERT > 1 ? $clog2(P_NUM_VERT) : 1)-1:0] o_vert_idx,
    output logic [(P_SUB_H > 1 ? $clog2(P_SUB_H) : 1)-1:0]     o_row,
    output logic [P_ADDR_BITS-1:0]                             o_bram_addr,
    output logic [1:0]                                         o_next_loc,
    output logic [1:0]                                         o_curr_loc,
    output logic [1:0]                                         o_prev_loc,
    output logic                                               o_frame_done,
    output logic                                               o_frame_err
);

    localparam int VB = P_NUM_VERT > 1 ? $clog2(P_NUM_VERT) : 1;
    localparam int RB = P_SUB_H > 1 ? $clog2(P_SUB_H) : 1;
    localparam int LB = P_LINE_BITS;
    localparam int AB = P_ADDR_BITS;
    localparam logic [LB-1:0] EDGE_L   = LB'(P_EDGE);
    localparam logic [LB-1:0] STEP     = LB'(P_SUB_H + P_GAP);
    localparam logic [LB-1:0] LAST_ROW = LB'(P_SUB_H - 1);
    localparam logic [VB-1:0] LAST_IDX = VB'(P_NUM_VERT - 1);

    if (P_EDGE + P_NUM_VERT * P_SUB_H + (P_NUM_VERT - 1) * P_GAP > P_LINES) begin : g_geom_err
        $error("sub-image windows do not fit inside the frame");
    end
    if (3 * P_SUB_H > 2 ** P_ADDR_BITS) begin : g_addr_err
        $error("three frame slots do not fit in the BRAM address space");
    end

    state_t        state, state_n;
    logic [LB-1:0] r_win_start, win_n, diff;
    logic [VB-1:0] r_idx, idx_n, vidx_n;
    logic [RB-1:0] row_n;
    logic [AB-1:0] addr_n, base;
    logic [1:0]    next_eff;
    logic          r_complete, cmp_n, valid_n, done_n, err_n, rotate, hit;

    gcbp_frame_slot_rotator u_slots (
        .i_clk    (i_clk),
        .i_resetn (i_resetn),
        .i_rotate (rotate),
        .o_next   (o_next_loc),
        .o_curr   (o_curr_loc),
        .o_prev   (o_prev_loc)
    );

    // frame strobe is resolved first so a same-cycle line is judged against the fresh window
    always_comb begin
        state_n = state;
        win_n   = r_win_start;
        idx_n   = r_idx;
        cmp_n   = r_complete;
        valid_n = o_line_valid;
        vidx_n  = o_vert_idx;
        row_n   = o_row;
        addr_n  = o_bram_addr;
        done_n  = 1'b0;
        err_n   = 1'b0;
        rotate  = 1'b0;
        if (i_enable && i_new_frame) begin
            rotate  = state != S_IDLE && r_complete;
            err_n   = state != S_IDLE && !r_complete;
            state_n = S_WAIT;
            win_n   = EDGE_L;
            idx_n   = '0;
            cmp_n   = 1'b0;
            valid_n = 1'b0;
        end
        next_eff = rotate ? o_prev_loc : o_next_loc;
        base     = next_eff == 2'd0 ? '0 : next_eff == 2'd1 ? AB'(P_SUB_H) : AB'(2 * P_SUB_H);
        diff     = i_line_cnt - win_n;
        hit      = i_enable && i_new_line && (state_n == S_ACTIVE || (state_n == S_WAIT && diff == '0));
        if (i_enable && i_new_line)
            valid_n = hit;
        if (hit) begin
            vidx_n  = idx_n;
            row_n   = diff[RB-1:0];
            addr_n  = base + AB'(diff[RB-1:0]);
            state_n = S_ACTIVE;
            if (diff == LAST_ROW) begin
                if (idx_n == LAST_IDX) begin
                    done_n  = 1'b1;
                    cmp_n   = 1'b1;
                    state_n = S_TAIL;
                end else begin
                    idx_n   = idx_n + VB'(1);
                    win_n   = win_n + STEP;
                    state_n = S_WAIT;
                end
            end
        end
        if (!i_enable) begin
            state_n = S_IDLE;
            valid_n = 1'b0;
        end
    end

    // register scheduler state and every output
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            state        <= S_IDLE;
            r_win_start  <= EDGE_L;
            r_idx        <= '0;
            r_complete   <= 1'b0;
            o_line_valid <= 1'b0;
            o_vert_idx   <= '0;
            o_row        <= '0;
            o_bram_addr  <= '0;
            o_frame_done <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            state        <= state_n;
            r_win_start  <= win_n;
            r_idx        <= idx_n;
            r_complete   <= cmp_n;
            o_line_valid <= valid_n;
            o_vert_idx   <= vidx_n;
            o_row        <= row_n;
            o_bram_addr  <= addr_n;
            o_frame_done <= done_n;
            o_frame_err  <= err_n;
        end
    end

endmodule
